// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Brief    : Shared constants and state encoding for the BCD sink.
// Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    // Input word width and number of packed BCD digits.
    localparam int W = 32;
    localparam int D = 10;

    // Controller states.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ACK  = 3'd1,
        S_CONV = 3'd2,
        S_LEN  = 3'd3,
        S_W0   = 3'd4,
        S_W1   = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dabble_step.sv
`default_nettype none
// ============================================================================
// Module   : dabble_step
// Brief    : One double-dabble iteration: add 3 to every digit >= 5, then
//            shift the BCD vector left by one, pulling in the binary MSB.
// Revision : 1.0 - initial release
// ============================================================================
module dabble_step
    import bcd_pkg::*;
#(
    parameter int D = bcd_pkg::D
) (
    input  logic [4*D-1:0] bcd,
    input  logic           bin_msb,
    output logic [4*D-1:0] bcd_next
);

    // Adjusted digits before the shift. The top digit's MSB is shifted out,
    // so only its low three bits are kept.
    logic [4*D-2:0] w_adj;

    for (genvar i = 0; i < D; i++) begin : g_digit
        logic [3:0] w_dig;
        assign w_dig = bcd[4*i +: 4];

        if (i < D-1) begin : g_low
            assign w_adj[4*i +: 4] = (w_dig >= 4'd5) ? (w_dig + 4'd3) : w_dig;
        end else begin : g_top
            assign w_adj[4*i +: 3] = 3'(w_dig + ((w_dig >= 4'd5) ? 4'd3 : 4'd0));
        end
    end

    assign bcd_next = {w_adj, bin_msb};

endmodule
`default_nettype wire

// File: rtl/bcd_sink.sv
`default_nettype none
// ============================================================================
// Module   : bcd_sink
// Brief    : Accepts a binary word over a dav_/rfd handshake, converts it to
//            packed BCD one bit per clock, counts significant digits and
//            offers {bcd, len} downstream over a second dav_/rfd handshake.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_sink
    import bcd_pkg::*;
#(
    parameter int W = bcd_pkg::W,
    parameter int D = bcd_pkg::D
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           dav_,
    output logic           rfd,
    input  logic [W-1:0]   in,
    output logic           dav_out_,
    input  logic           rfd_in,
    output logic [4*D-1:0] bcd_out,
    output logic [3:0]     len_out
);

    localparam logic [5:0] c_cnt_init = 6'(W);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_bin;
    logic [4*D-1:0] r_bcd;
    logic [5:0]     r_cnt;
    logic [4*D-1:0] w_bcd_step;
    logic [3:0]     w_len;

    dabble_step #(.D(D)) u_dabble_step (
        .bcd      (r_bcd),
        .bin_msb  (r_bin[W-1]),
        .bcd_next (w_bcd_step)
    );

    // Significant digit count: position of the highest non-zero digit, min 1.
    always_comb begin
        w_len = 4'd1;
        for (int i = 0; i < D; i++) begin
            if (r_bcd[4*i +: 4] != 4'd0) begin
                w_len = 4'(i + 1);
            end
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic for both handshakes and the fixed-length conversion.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (!dav_)            w_state_nxt = S_ACK;
            S_ACK:   if (dav_)             w_state_nxt = S_CONV;
            S_CONV:  if (r_cnt == 6'd1)    w_state_nxt = S_LEN;
            S_LEN:                         w_state_nxt = S_W0;
            S_W0:    if (!rfd_in)          w_state_nxt = S_W1;
            S_W1:    if (rfd_in)           w_state_nxt = S_IDLE;
            default:                       w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath and registered handshake outputs, advanced per current state.
    always_ff @(posedge clock) begin
        if (reset) begin
            rfd      <= 1'b1;
            dav_out_ <= 1'b1;
            bcd_out  <= '0;
            len_out  <= 4'd1;
            r_bin    <= '0;
            r_bcd    <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!dav_) begin
                        r_bin <= in;
                        r_bcd <= '0;
                        r_cnt <= c_cnt_init;
                        rfd   <= 1'b0;
                    end
                end
                S_CONV: begin
                    r_bcd <= w_bcd_step;
                    r_bin <= {r_bin[W-2:0], 1'b0};
                    r_cnt <= r_cnt - 6'd1;
                end
                S_LEN: begin
                    bcd_out  <= r_bcd;
                    len_out  <= w_len;
                    dav_out_ <= 1'b0;
                end
                S_W0: begin
                    if (!rfd_in) begin
                        dav_out_ <= 1'b1;
                    end
                end
                S_W1: begin
                    if (rfd_in) begin
                        rfd <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_sink
// Brief    : Directed self-checking bench for bcd_sink.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_sink;

    localparam int W = 32;
    localparam int D = 10;

    logic           clock = 1'b0;
    logic           reset;
    logic           dav_;
    logic           rfd;
    logic [W-1:0]   in_w;
    logic           dav_out_;
    logic           rfd_in;
    logic [4*D-1:0] bcd_out;
    logic [3:0]     len_out;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    bcd_sink #(.W(W), .D(D)) dut (
        .clock    (clock),
        .reset    (reset),
        .dav_     (dav_),
        .rfd      (rfd),
        .in       (in_w),
        .dav_out_ (dav_out_),
        .rfd_in   (rfd_in),
        .bcd_out  (bcd_out),
        .len_out  (len_out)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rfd(input logic lvl, input string tag);
        int k = 0;
        while (rfd !== lvl && k < 200) begin
            @(negedge clock);
            k++;
        end
        check(tag, 64'(rfd), 64'(lvl));
    endtask

    task automatic wait_dav_out(input logic lvl, input string tag, output int n);
        n = 0;
        while (dav_out_ !== lvl && n < 200) begin
            @(negedge clock);
            n++;
        end
        check(tag, 64'(dav_out_), 64'(lvl));
    endtask

    // One complete transfer with optional downstream stall.
    task automatic xfer(input logic [W-1:0] val, input logic [4*D-1:0] eb,
                        input logic [3:0] el, input bit stall, input string tag);
        int n;
        wait_rfd(1'b1, {tag, ":rfd_ready"});
        in_w = val;
        dav_ = 1'b0;
        @(negedge clock);
        check({tag, ":accept"}, 64'(rfd), 64'd0);
        dav_ = 1'b1;
        in_w = 32'hDEAD_BEEF;
        wait_dav_out(1'b0, {tag, ":dav_out_fall"}, n);
        // dav_ raise -> S_CONV entry (1 edge) + W+1 edges to dav_out_ falling.
        check({tag, ":latency"}, 64'(n), 64'(W + 2));
        check({tag, ":bcd"}, 64'(bcd_out), 64'(eb));
        check({tag, ":len"}, 64'(len_out), 64'(el));
        if (stall) begin
            dav_ = 1'b0;
            in_w = 32'd5;
            for (int c = 0; c < 20; c++) begin
                @(negedge clock);
                check({tag, ":stall_dav_out"}, 64'(dav_out_), 64'd0);
                check({tag, ":stall_rfd"}, 64'(rfd), 64'd0);
            end
            dav_ = 1'b1;
            check({tag, ":stall_bcd"}, 64'(bcd_out), 64'(eb));
            check({tag, ":stall_len"}, 64'(len_out), 64'(el));
        end
        rfd_in = 1'b0;
        wait_dav_out(1'b1, {tag, ":dav_out_rise"}, n);
        rfd_in = 1'b1;
        wait_rfd(1'b1, {tag, ":rfd_return"});
        @(negedge clock);
        check({tag, ":hold_bcd"}, 64'(bcd_out), 64'(eb));
        check({tag, ":idle_dav_out"}, 64'(dav_out_), 64'd1);
    endtask

    initial begin
        reset  = 1'b1;
        dav_   = 1'b1;
        rfd_in = 1'b1;
        in_w   = '0;
        repeat (2) @(negedge clock);
        check("rst_rfd", 64'(rfd), 64'd1);
        check("rst_dav_out", 64'(dav_out_), 64'd1);
        check("rst_bcd", 64'(bcd_out), 64'd0);
        check("rst_len", 64'(len_out), 64'd1);
        reset = 1'b0;
        @(negedge clock);

        xfer(32'd0,          40'h00_0000_0000, 4'd1,  1'b0, "zero");
        xfer(32'd832040,     40'h00_0083_2040, 4'd6,  1'b1, "f30");
        xfer(32'd9,          40'h00_0000_0009, 4'd1,  1'b0, "nine");
        xfer(32'd10,         40'h00_0000_0010, 4'd2,  1'b0, "ten");
        xfer(32'hFFFF_FFFF,  40'h42_9496_7295, 4'd10, 1'b0, "max");

        // Abort a conversion with a one-cycle reset.
        wait_rfd(1'b1, "abort:rfd_ready");
        in_w = 32'd12345;
        dav_ = 1'b0;
        @(negedge clock);
        dav_ = 1'b1;
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_rfd", 64'(rfd), 64'd1);
        check("abort_dav_out", 64'(dav_out_), 64'd1);
        check("abort_bcd", 64'(bcd_out), 64'd0);
        check("abort_len", 64'(len_out), 64'd1);
        repeat (40) @(negedge clock);
        check("abort_no_stale", 64'(dav_out_), 64'd1);

        xfer(32'd7,          40'h00_0000_0007, 4'd1,  1'b0, "seven");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/bcd_sink.md
Name: bcd_sink

Overview:
- Downstream consumer of the Fibonacci stage. Connects to its B-side port (dav_b_/rfd_b, 32-bit out).
- Accepts one 32-bit unsigned word per dav_/rfd handshake.
- Converts the word to 10-digit packed BCD with an iterative shift-and-add-3 (double dabble), one bit per clock.
- Counts significant decimal digits and offers {bcd, len} to the display stage through a second dav_/rfd handshake.

Parameters:
- W, 32, input word width.
- D, 10, BCD digits; 4*D must cover 2^W-1.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- dav_   in  1  upstream data valid, active low.
- rfd    out 1  to upstream; 1 = ready for data.
- in     in  W  upstream data word; valid while dav_=0.
- dav_out_  out 1  downstream data valid, active low.
- rfd_in    in  1  from downstream; 1 = ready.
- bcd_out   out 4*D  packed BCD; digit 0 is in bits [3:0].
- len_out   out 4  number of significant digits, 1..D.

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-high.
  - Reset wins over every other condition in the same cycle.
  - Reset values: STAR=S_IDLE, rfd=1, dav_out_=1, bcd_out=0, len_out=1, BIN=0, CNT=0.
  - Reset mid-conversion or mid-handshake aborts the transfer. The partial result is discarded.
- Registers: BIN[W-1:0], BCD[4D-1:0], CNT (6 bit), STAR (3 bit), plus the registered outputs.
- S_IDLE: rfd=1.
  - If dav_=0: BIN<=in, BCD<=0, CNT<=W, rfd<=0, go to S_ACK.
  - Otherwise stay.
- S_ACK: wait for dav_=1, then go to S_CONV. rfd stays 0.
- S_CONV, one step per clock:
  - For each digit, if digit>=5 add 3 (4-bit, no carry out).
  - Then shift {BCD,BIN} left by 1.
  - CNT<=CNT-1.
  - When CNT==1 (the W-th step), go to S_LEN.
  - Exactly W steps; no early exit for small values.
- S_LEN:
  - bcd_out<=BCD.
  - len_out <= index of the highest non-zero digit + 1; 1 if BCD==0.
  - dav_out_<=0.
  - Go to S_W0.
- S_W0: hold dav_out_=0 and the outputs stable. When rfd_in=0, set dav_out_<=1 and go to S_W1.
- S_W1: when rfd_in=1, set rfd<=1 and go to S_IDLE.
- rfd outside S_IDLE:
  - rfd stays 0 from acceptance until the downstream handshake completes. Only one word is in flight.
  - A dav_ low seen outside S_IDLE is ignored until S_IDLE.
- Latency: 1 cycle from dav_ rising (seen in S_ACK) to S_CONV. Then W cycles of conversion. dav_out_ falls at the edge after the last step, which is W+1 edges after S_CONV entry.
- Arithmetic:
  - All unsigned.
  - The add-3 never overflows a digit because the value is at most 9 before the shift.
  - The top digit of 2^32-1 is 4, so D=10 suffices and no digit is lost.
- Output stability: bcd_out/len_out change only in S_LEN and on reset. They hold between transfers.

Decomposition:
- Shared package bcd_pkg:
  - State localparams S_IDLE=0, S_ACK=1, S_CONV=2, S_LEN=3, S_W0=4, S_W1=5.
  - W, D.
- One combinational sub-module, dabble_step. Inputs: bcd[4D-1:0], bin_msb. Output: next bcd. It performs the add-3 on every digit, then the shift.
  - The bit shifted into digit 0 is BIN's MSB before the shift.
  - Instantiated once inside bcd_sink.
- The digit-count priority encoder stays inline.

Test Plan:
- in=32'd0, downstream always ready → bcd_out=40'h0, len_out=1. dav_out_ low W+1 cycles after S_CONV entry.
- in=32'd832040 (F30) → bcd_out=40'h0000832040, len_out=6.
- in=32'd9, then in=32'd10 → 40'h9 with len 1, then 40'h10 with len 2 (digit boundary). Two back-to-back transfers; the second is accepted only after rfd returns to 1.
- in=32'hFFFFFFFF → bcd_out=40'h4294967295, len_out=10 (maximum width, no truncation).
- Downstream stall: rfd_in held 1 for 20 cycles after dav_out_ falls → dav_out_ stays 0, outputs stable, rfd stays 0, and a new upstream dav_=0 is not accepted.
- reset=1 for one cycle midway through S_CONV (in=12345) → next cycle rfd=1, dav_out_=1, bcd_out=0, len_out=1. A new transfer in=7 then yields 40'h7, len 1.
